// File: rtl/seq_det_param.sv
// Purpose : runtime-configurable Mealy serial-pattern detector with overlap mode,
//           input qualification, saturating match counter and config-error flag.
// Latency : OP is combinational (same cycle as final bit); Match_Cnt/Fill/Cfg_Err one edge later.
// Backpr. : none; a bit is consumed only when In_Valid=1, otherwise all state holds.
//
// Ports:
//   Clk, Rst          clock and synchronous active-high reset
//   In, In_Valid      serial data bit and its qualifier
//   Cfg_Load          one-cycle pulse latching Pattern/Len/Ovl and flushing history
//   Pattern, Len, Ovl pattern bits (Pattern[Len-1] arrives first), length, overlap mode
//   Cnt_Clr           clears the match counter
//   OP                Mealy match strobe
//   Match_Cnt         saturating match count
//   Fill              fresh bits currently held toward a match
//   Cfg_Err           latched configuration is illegal; detector disabled
module seq_det_param #(
   parameter int                 MAX_LEN = 8,
   parameter int                 LEN_W   = 4,
   parameter int                 CNT_W   = 8,
   parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_1010),
   parameter logic [LEN_W-1:0]   RST_LEN = LEN_W'(4),
   parameter logic               RST_OVL = 1'b1
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               In,
   input  logic               In_Valid,
   input  logic               Cfg_Load,
   input  logic [MAX_LEN-1:0] Pattern,
   input  logic [LEN_W-1:0]   Len,
   input  logic               Ovl,
   input  logic               Cnt_Clr,
   output logic               OP,
   output logic [CNT_W-1:0]   Match_Cnt,
   output logic [LEN_W-1:0]   Fill,
   output logic               Cfg_Err
);

   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic               err_q;
   logic [MAX_LEN-2:0] hist_q;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [LEN_W-1:0]   len_m1;
   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] mask;
   logic               pat_hit;
   logic               accept;
   logic               cfg_bad;
   logic [CNT_W-1:0]   cnt_base;

   assign len_m1 = len_q - LEN_W'(1);

   // Candidate window: stored history with the current bit appended as the newest.
   assign window = {hist_q, In};

   // Only the low len_q bits of window and pattern take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len_q)) mask[i] = 1'b1;
      end
   end

   assign pat_hit = ((window ^ pat_q) & mask) == '0;
   assign accept  = In_Valid & ~Rst & ~Cfg_Load & ~err_q;

   // fill_q >= len-1 guarantees every compared history bit arrived after the last flush.
   assign OP = accept & (fill_q >= len_m1) & pat_hit;

   assign cfg_bad = (Len < LEN_W'(2)) | (int'(Len) > MAX_LEN);

   always_comb begin
      fill_d = fill_q;
      if (OP) begin
         // Overlap keeps a full window so the next bit may complete another match.
         fill_d = ovl_q ? len_m1 : '0;
      end else if (fill_q < len_m1) begin
         fill_d = fill_q + LEN_W'(1);
      end else begin
         fill_d = len_m1;
      end
   end

   // Clear is applied first so a clear coinciding with a match leaves a count of one.
   always_comb begin
      cnt_base = Cnt_Clr ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (OP && (cnt_base != '1)) cnt_d = cnt_base + CNT_W'(1);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pat_q  <= RST_PAT;
         len_q  <= RST_LEN;
         ovl_q  <= RST_OVL;
         err_q  <= 1'b0;
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (Cfg_Load) begin
            pat_q  <= Pattern;
            len_q  <= Len;
            ovl_q  <= Ovl;
            err_q  <= cfg_bad;
            hist_q <= '0;
            fill_q <= '0;
         end else if (accept) begin
            hist_q <= {hist_q[MAX_LEN-3:0], In};
            fill_q <= fill_d;
         end
      end
   end

   assign Match_Cnt = cnt_q;
   assign Fill      = fill_q;
   assign Cfg_Err   = err_q;

endmodule

// File: tb/tb_seq_det_param.sv
module tb_seq_det_param;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               Clk = 1'b0;
   logic               Rst;
   logic               In;
   logic               In_Valid;
   logic               Cfg_Load;
   logic [MAX_LEN-1:0] Pattern;
   logic [LEN_W-1:0]   Len;
   logic               Ovl;
   logic               Cnt_Clr;
   logic               OP;
   logic [CNT_W-1:0]   Match_Cnt;
   logic [LEN_W-1:0]   Fill;
   logic               Cfg_Err;

   always #5 Clk = ~Clk;

   seq_det_param #(
      .MAX_LEN(MAX_LEN),
      .LEN_W  (LEN_W),
      .CNT_W  (CNT_W)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .In       (In),
      .In_Valid (In_Valid),
      .Cfg_Load (Cfg_Load),
      .Pattern  (Pattern),
      .Len      (Len),
      .Ovl      (Ovl),
      .Cnt_Clr  (Cnt_Clr),
      .OP       (OP),
      .Match_Cnt(Match_Cnt),
      .Fill     (Fill),
      .Cfg_Err  (Cfg_Err)
   );

   typedef struct {
      bit op;
      int cnt;
      int fill;
      bit err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: list of fresh accepted bits since the last flush.
   logic [MAX_LEN-1:0] m_pat;
   int                 m_len;
   bit                 m_ovl;
   bit                 m_err;
   int                 m_cnt;
   bit                 m_bits[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pat = MAX_LEN'(8'b0000_1010);
      m_len = 4;
      m_ovl = 1'b1;
      m_err = 1'b0;
      m_cnt = 0;
      m_bits.delete();
   endtask

   // Drive one cycle (called just after a rising edge), queue the expected outputs
   // for this cycle, advance the model, and wait for the next edge.
   task automatic cyc(input bit rst, input bit vld, input bit din, input bit cfg,
                      input logic [MAX_LEN-1:0] pat, input int len, input bit ovl,
                      input bit clr);
      exp_t e;
      bit   op;
      int   sz;
      Rst      = rst;
      In       = din;
      In_Valid = vld;
      Cfg_Load = cfg;
      Pattern  = pat;
      Len      = LEN_W'(len);
      Ovl      = ovl;
      Cnt_Clr  = clr;

      sz = m_bits.size();
      op = 1'b0;
      if (!rst && !cfg && vld && !m_err && sz >= m_len - 1) begin
         op = 1'b1;
         for (int j = 0; j < m_len; j++) begin
            bit b;
            b = (j == m_len - 1) ? din : m_bits[sz - (m_len - 1) + j];
            if (b != m_pat[m_len - 1 - j]) op = 1'b0;
         end
      end
      e.op   = op;
      e.cnt  = m_cnt;
      e.err  = m_err;
      e.fill = m_err ? 0 : ((sz < m_len - 1) ? sz : m_len - 1);
      sb_q.push_back(e);

      if (rst) begin
         model_reset();
      end else begin
         if (clr) m_cnt = 0;
         if (op && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         if (cfg) begin
            m_pat = pat;
            m_len = len;
            m_ovl = ovl;
            m_err = (len < 2) || (len > MAX_LEN);
            m_bits.delete();
         end else if (vld && !m_err) begin
            m_bits.push_back(din);
            if (op && !m_ovl) m_bits.delete();
            while (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
         end
      end

      @(posedge Clk);
      #1;
   endtask

   task automatic bitc(input bit vld, input bit din);
      cyc(1'b0, vld, din, 1'b0, '0, 0, 1'b0, 1'b0);
   endtask

   task automatic cfgc(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
   endtask

   // Monitor: every cycle the DUT presents a Mealy strobe plus registered state.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("OP", int'(OP), int'(e.op));
            check("Match_Cnt", int'(Match_Cnt), e.cnt);
            check("Fill", int'(Fill), e.fill);
            check("Cfg_Err", int'(Cfg_Err), int'(e.err));
         end
      end
   end

   initial begin
      logic [MAX_LEN-1:0] p;
      Rst = 1'b1; In = 1'b0; In_Valid = 1'b0; Cfg_Load = 1'b0;
      Pattern = '0; Len = '0; Ovl = 1'b0; Cnt_Clr = 1'b0;
      model_reset();
      @(posedge Clk);
      #1;

      // Reset state, then default 1010 overlapping.
      cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) bitc(1'b1, (i % 2) == 0);

      // Non-overlapping 1010.
      cfgc(8'h0A, 4, 1'b0);
      for (int i = 0; i < 8; i++) bitc(1'b1, (i % 2) == 0);

      // Full-length pattern with idle gaps.
      p = 8'b1100_1011;
      cfgc(p, 8, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         bitc(1'b1, p[i]);
         bitc(1'b0, 1'($urandom_range(0, 1)));
      end

      // Illegal length, then recovery with a legal one.
      cfgc(8'hFF, 1, 1'b1);
      for (int i = 0; i < 4; i++) bitc(1'b1, 1'b1);
      cfgc(8'b101, 3, 1'b1);
      bitc(1'b1, 1'b1); bitc(1'b1, 1'b0); bitc(1'b1, 1'b1);

      // Pattern 11 overlapping: counter saturation, then clear coinciding with a match.
      cfgc(8'b11, 2, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) bitc(1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
      bitc(1'b0, 1'b0);

      // Reset mid-sequence discards partial history.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
      bitc(1'b1, 1'b1); bitc(1'b1, 1'b0); bitc(1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
      bitc(1'b1, 1'b0);
      bitc(1'b1, 1'b1); bitc(1'b1, 1'b0); bitc(1'b1, 1'b1); bitc(1'b1, 1'b0);

      // Randomized traffic with occasional reconfiguration, clears and resets.
      for (int n = 0; n < 3000; n++) begin
         int r;
         int len;
         r   = $urandom_range(0, 99);
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 4);
         cyc(r < 1, $urandom_range(0, 99) < 80, 1'($urandom_range(0, 1)),
             (r >= 1) && (r < 4), MAX_LEN'($urandom), len, 1'($urandom_range(0, 1)),
             $urandom_range(0, 29) == 0);
      end

      In_Valid = 1'b0; Cfg_Load = 1'b0; Rst = 1'b0; Cnt_Clr = 1'b0;
      repeat (3) @(posedge Clk);
      check("sb_drain", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised Mealy serial-pattern detector, the generalised successor to the fixed-pattern detectors in the FSM series. Pattern bits, pattern length (2..MAX_LEN) and overlap/non-overlap mode are runtime-configurable. It also adds input qualification, a saturating match counter and a config-error flag. It sits directly on a serial bit stream and drives a one-cycle Mealy match strobe.

## Interface
- MAX_LEN, 8, longest supported pattern (≥4)
- LEN_W, 4, width of Len; must hold MAX_LEN
- CNT_W, 8, match counter width
- RST_PAT, 8'b0000_1010, pattern loaded by reset (low LEN bits used)
- RST_LEN, 4, length loaded by reset
- RST_OVL, 1, overlap mode loaded by reset
- Clk  input  1  clock, all state on rising edge
- Rst  input  1  synchronous, active-high reset
- In  input  1  serial data bit
- In_Valid  input  1  In sampled only when 1
- Cfg_Load  input  1  one-cycle pulse: latch Pattern/Len/Ovl, flush history
- Pattern  input  MAX_LEN  Pattern[Len-1] = first bit received, Pattern[0] = last
- Len  input  LEN_W  pattern length
- Ovl  input  1  1 = overlapping, 0 = non-overlapping
- Cnt_Clr  input  1  clear match counter
- OP  output  1  Mealy match strobe (combinational from state + In)
- Match_Cnt  output  CNT_W  saturating match count
- Fill  output  LEN_W  bits currently held toward a match (0..Len-1); the current state
- Cfg_Err  output  1  latched config is illegal; detector disabled

## Operation
- Internal regs: pat_q[MAX_LEN], len_q, ovl_q, err_q, hist[MAX_LEN-1] (shift register, newest in bit 0), fill_q, cnt_q.
- OP = In_Valid & !err_q & !Rst & !Cfg_Load & (fill_q ≥ len_q-1) & ({hist[len_q-2:0], In} == pat_q[len_q-1:0]).
- On accepted bit (In_Valid=1, no Rst/Cfg_Load): hist <= {hist, In}.
  - No match: fill_q <= min(fill_q+1, len_q-1).
  - Match, ovl_q=1: fill_q stays len_q-1, so the next bit can complete an overlapping match.
  - Match, ovl_q=0: fill_q <= 0; history bits of the matched pattern are not reused.
- In_Valid=0: all state holds and OP=0.
- Cfg_Load: pat_q/len_q/ovl_q <= inputs. hist <= 0, fill_q <= 0. err_q <= (Len<2 | Len>MAX_LEN). cnt_q unaffected. In is ignored that cycle.
- err_q=1: OP held 0, fill_q held 0; cleared only by a legal Cfg_Load or Rst.
- Counter: cnt_q increments on OP and saturates at 2^CNT_W-1. Cnt_Clr alone gives 0. Cnt_Clr with OP in the same cycle gives 1.
- Priority: Rst > Cfg_Load > normal operation.

## Timing
- Rst (sampled at edge): pat_q=RST_PAT, len_q=RST_LEN, ovl_q=RST_OVL, err_q=0, hist=0, fill_q=0, cnt_q=0.
- Outputs in reset: OP=0, Match_Cnt=0, Fill=0, Cfg_Err=0.
- OP has zero latency: it asserts in the same cycle as the final pattern bit, before the edge that consumes it.
- Match_Cnt and Fill update at the edge that consumes the bit, i.e. 1 cycle after OP.
- New config is in effect from the cycle after Cfg_Load. Cfg_Err is visible 1 cycle after Cfg_Load.
- Rst asserted mid-sequence discards partial history. A match needs Len fresh valid bits after Rst deasserts.

## Test plan
- Default config (1010, Len 4, overlap), In = 1,0,1,0,1,0,1,0 with In_Valid=1 -> OP high on bits 4, 6, 8; Match_Cnt=3 after the last edge.
- Cfg_Load with Pattern=1010, Len=4, Ovl=0, then the same stream -> OP only on bits 4 and 8; Fill reads 0 after bit 4; Match_Cnt=2.
- Load Len=8, Pattern=8'b1100_1011, feed it with In_Valid=0 gaps between bits -> single OP on the 8th valid bit; OP=0 in every gap cycle.
- Cfg_Load with Len=1, then stream 1111 -> Cfg_Err=1 and OP never asserts. Legal Cfg_Load with Len=3 -> Cfg_Err=0.
- CNT_W=2, overlap pattern 11 (Len 2), stream of six 1s -> 5 matches; Match_Cnt saturates at 3. Cnt_Clr in the same cycle as an OP -> Match_Cnt=1.
- Feed 1,0,1, assert Rst for one cycle, then 0 -> no OP. Then 1,0,1,0 -> OP on the 4th bit.
